// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring divide for the EX stage.
// Stalls the pipeline while running and commits the 2xWIDTH result to Hi/Lo.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFixup, StDone} stateT;

  stateT            state, nextState;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] accHi, accLo, opB;
  logic             isDiv, resNeg, remNeg;

  logic             accept, divZero;
  logic [WIDTH-1:0] absA, absB, addend;
  logic [WIDTH:0]   mulSum, remShift;
  logic [WIDTH+1:0] trial;
  logic [2*WIDTH-1:0] prod, prodFix;
  logic [WIDTH-1:0] hiFix, loFix;

  assign accept  = (state == StIdle) && Start && !Flush;
  assign divZero = Op[1] && (SrcB == '0);
  assign absA    = (Op[0] && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign absB    = (Op[0] && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  // One iteration of shift-add multiply and restoring divide
  assign addend   = accLo[0] ? opB : '0;
  assign mulSum   = {1'b0, accHi} + {1'b0, addend};
  assign remShift = {accHi, accLo[WIDTH-1]};
  assign trial    = {1'b0, remShift} - {2'b00, opB};

  // Sign correction applied on the FIXUP -> DONE edge
  assign prod    = {accHi, accLo};
  assign prodFix = resNeg ? -prod : prod;
  always_comb begin
    hiFix = prodFix[2*WIDTH-1:WIDTH];
    loFix = prodFix[WIDTH-1:0];
    if (isDiv) begin
      hiFix = remNeg ? -accHi : accHi;
      loFix = resNeg ? -accLo : accLo;
    end
  end

  // State register; Busy/Done are flops decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= nextState;
      Busy  <= (nextState != StIdle);
      Done  <= (nextState == StDone);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      StIdle:  if (accept) nextState = divZero ? StDone : StRun;
      StRun:   if (Flush) nextState = StIdle;
               else if (cnt == '0) nextState = StFixup;
      StFixup: nextState = Flush ? StIdle : StDone;
      StDone:  nextState = StIdle;
      default: nextState = StIdle;
    endcase
  end

  always_comb begin
    Stall = 1'b0;
    if (state != StIdle) Stall = 1'b1;
    else if (Start && !Flush) Stall = 1'b1;
  end

  // Datapath: operand latch, iteration and result commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      accHi     <= '0;
      accLo     <= '0;
      opB       <= '0;
      isDiv     <= 1'b0;
      resNeg    <= 1'b0;
      remNeg    <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        StIdle: if (accept) begin
          isDiv     <= Op[1];
          resNeg    <= Op[0] && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          remNeg    <= Op[0] && SrcA[WIDTH-1];
          cnt       <= CntW'(WIDTH-1);
          accHi     <= '0;
          DivByZero <= divZero;
          if (Op[1]) begin
            accLo <= absA;
            opB   <= absB;
          end else begin
            accLo <= absB;
            opB   <= absA;
          end
          if (divZero) begin
            Hi <= SrcA;
            Lo <= '1;
          end
        end
        StRun: if (!Flush) begin
          if (cnt != '0) cnt <= cnt - CntW'(1);
          if (isDiv) begin
            if (!trial[WIDTH+1]) begin
              accHi <= trial[WIDTH-1:0];
              accLo <= {accLo[WIDTH-2:0], 1'b1};
            end else begin
              accHi <= remShift[WIDTH-1:0];
              accLo <= {accLo[WIDTH-2:0], 1'b0};
            end
          end else begin
            accHi <= mulSum[WIDTH:1];
            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
          end
        end
        StFixup: if (!Flush) begin
          Hi <= hiFix;
          Lo <= loFix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_muldiv_sequencer;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA, SrcB;
  logic             Flush;
  logic             Stall, Busy, Done, DivByZero;
  logic [WIDTH-1:0] Hi, Lo;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .Stall(Stall), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo),
    .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  // Issue one op and wait for Done. doneEdges = edges after the accepting edge
  // until Done is seen; stallCnt = Stall-high cycles after the accepting edge.
  task automatic runOp(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output int doneEdges, output int stallCnt, output logic preStall,
                       output logic timedOut);
    int n;
    @(negedge clk);
    Op = op; SrcA = a; SrcB = b; Start = 1'b1;
    #1 preStall = Stall;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    n = 0; stallCnt = 0;
    while (!Done && n < 200) begin
      if (Stall) stallCnt++;
      @(negedge clk);
      n++;
    end
    if (Stall) stallCnt++;
    doneEdges = n;
    timedOut = (n >= 200);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({Stall, Busy, Done, DivByZero} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {Stall, Busy, Done, DivByZero});
    end
    checks++;
    if (Hi !== '0 || Lo !== '0) begin
      errors++; $display("FAIL reset_hilo got %h_%h want 0_0", Hi, Lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu;
    int de, sc; logic ps, to;
    runOp(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, de, sc, ps, to);
    checks++;
    if (to) begin errors++; $display("FAIL multu_timeout no Done within bound"); end
    checks++;
    if (Hi !== 32'hFFFFFFFE || Lo !== 32'h00000001) begin
      errors++; $display("FAIL multu_result got %h_%h want fffffffe_00000001", Hi, Lo);
    end
    checks++;
    if (de !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", de); end
    checks++;
    if (sc !== 34) begin errors++; $display("FAIL multu_stall_cycles got %0d want 34", sc); end
    checks++;
    if (ps !== 1'b1) begin errors++; $display("FAIL multu_stall_same_cycle got %b want 1", ps); end
    @(negedge clk);
    checks++;
    if ({Stall, Busy, Done} !== 3'b000) begin
      errors++; $display("FAIL multu_release got %b want 000", {Stall, Busy, Done});
    end
  endtask

  task automatic test_flush;
    logic sawDone;
    sawDone = 1'b0;
    @(negedge clk);
    Op = 2'b00; SrcA = 32'd3; SrcB = 32'd5; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (4) begin @(negedge clk); sawDone |= Done; end
    Op = 2'b10; SrcA = 32'h55; SrcB = '0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; sawDone |= Done;
    checks++;
    if (Busy !== 1'b1 || DivByZero !== 1'b0) begin
      errors++; $display("FAIL start_while_busy busy=%b dbz=%b want 1 0", Busy, DivByZero);
    end
    repeat (4) begin @(negedge clk); sawDone |= Done; end
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Stall !== 1'b0) begin
      errors++; $display("FAIL flush_idle busy=%b stall=%b want 0 0", Busy, Stall);
    end
    repeat (40) begin sawDone |= Done; @(negedge clk); end
    checks++;
    if (sawDone !== 1'b0) begin errors++; $display("FAIL flush_no_done got Done pulse want none"); end
    checks++;
    if (Hi !== 32'hFFFFFFFE || Lo !== 32'h00000001 || DivByZero !== 1'b0) begin
      errors++; $display("FAIL flush_hilo got %h_%h dbz=%b want fffffffe_00000001 0", Hi, Lo, DivByZero);
    end
  endtask

  task automatic test_mult;
    int de, sc; logic ps, to;
    runOp(2'b01, 32'hFFFFFFFD, 32'd7, de, sc, ps, to);
    checks++;
    if (to || Hi !== 32'hFFFFFFFF || Lo !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mult_neg got %h_%h to=%b want ffffffff_ffffffeb", Hi, Lo, to);
    end
    runOp(2'b01, 32'hFFFFFFFD, 32'hFFFFFFF9, de, sc, ps, to);
    checks++;
    if (to || Hi !== 32'h0 || Lo !== 32'd21) begin
      errors++; $display("FAIL mult_negneg got %h_%h to=%b want 00000000_00000015", Hi, Lo, to);
    end
  endtask

  task automatic test_div;
    int de, sc; logic ps, to;
    runOp(2'b11, 32'hFFFFFFF9, 32'd2, de, sc, ps, to);
    checks++;
    if (to || Hi !== 32'hFFFFFFFF || Lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_neg got %h_%h to=%b want ffffffff_fffffffd", Hi, Lo, to);
    end
    runOp(2'b10, 32'd100, 32'd7, de, sc, ps, to);
    checks++;
    if (to || Hi !== 32'd2 || Lo !== 32'd14) begin
      errors++; $display("FAIL divu got %h_%h to=%b want 00000002_0000000e", Hi, Lo, to);
    end
    checks++;
    if (de !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", de); end
    runOp(2'b11, 32'h80000000, 32'hFFFFFFFF, de, sc, ps, to);
    checks++;
    if (to || Hi !== 32'h0 || Lo !== 32'h80000000 || DivByZero !== 1'b0) begin
      errors++; $display("FAIL div_overflow got %h_%h dbz=%b want 00000000_80000000 0", Hi, Lo, DivByZero);
    end
  endtask

  task automatic test_divzero;
    int de, sc; logic ps, to;
    runOp(2'b10, 32'h1234, 32'h0, de, sc, ps, to);
    checks++;
    if (to || de !== 0) begin
      errors++; $display("FAIL dbz_latency got %0d edges after accept want 0", de);
    end
    checks++;
    if (ps + sc !== 2) begin errors++; $display("FAIL dbz_stall_cycles got %0d want 2", ps + sc); end
    checks++;
    if (Hi !== 32'h1234 || Lo !== 32'hFFFFFFFF || DivByZero !== 1'b1) begin
      errors++; $display("FAIL dbz_result got %h_%h dbz=%b want 00001234_ffffffff 1", Hi, Lo, DivByZero);
    end
    runOp(2'b00, 32'h00010000, 32'h00010000, de, sc, ps, to);
    checks++;
    if (to || DivByZero !== 1'b0 || Hi !== 32'h1 || Lo !== 32'h0) begin
      errors++; $display("FAIL dbz_clear got %h_%h dbz=%b want 00000001_00000000 0", Hi, Lo, DivByZero);
    end
  endtask

  task automatic test_reset_mid;
    int de, sc; logic ps, to;
    @(negedge clk);
    Op = 2'b00; SrcA = 32'hFFFFFFFF; SrcB = 32'h12345678; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({Stall, Busy, Done, DivByZero} !== 4'b0000 || Hi !== '0 || Lo !== '0) begin
      errors++; $display("FAIL reset_mid got flags=%b hilo=%h_%h want 0", {Stall, Busy, Done, DivByZero}, Hi, Lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    runOp(2'b00, 32'd3, 32'd5, de, sc, ps, to);
    checks++;
    if (to || Hi !== 32'h0 || Lo !== 32'd15) begin
      errors++; $display("FAIL after_reset_multu got %h_%h to=%b want 00000000_0000000f", Hi, Lo, to);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_flush();
    test_mult();
    test_div();
    test_divzero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
